if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  Fetch front end plus IF/ID pipeline register of the 5-stage RISC-V lab CPU.
//  Owns the PC and issues one instruction-memory request at a time over a req/rvalid handshake.
//  Delivers {pc, instr, valid} to ID, where the immediate generator and decoder consume id_instr_o.
//  Honours load-use stall and branch-taken flush/redirect from the hazard unit and ID branch logic.
// PARAMETERS
//  XLEN      32            datapath / address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INSTR 32'h0000_0013 addi x0,x0,0; loaded into IF/ID on reset and on flush
// PORTS
//  clk_i            in   1     clock, all state updates on rising edge
//  rst_i            in   1     synchronous reset, active-high
//  stall_i          in   1     hazard unit: hold IF/ID and PC (load-use)
//  flush_i          in   1     ID branch taken: squash fetch, redirect PC
//  branch_target_i  in   XLEN  redirect address, sampled when flush_i=1
//  imem_req_o       out  1     fetch request, 1-cycle pulse per fetch
//  imem_addr_o      out  XLEN  fetch address (= pc_q)
//  imem_rvalid_i    in   1     imem_rdata_i valid this cycle
//  imem_rdata_i     in   32    fetched instruction word
//  id_pc_o          out  XLEN  PC of instruction in IF/ID
//  id_instr_o       out  32    instruction in IF/ID
//  id_valid_o       out  1     IF/ID holds a real (non-bubble) instruction
// BEHAVIOUR
//  Reset (rst_i=1 on an edge): pc_q=RESET_PC, state=S_REQ, drop_q=0, hold buffer empty,
//   id_pc_o=0, id_instr_o=NOP_INSTR, id_valid_o=0. imem_req_o=0 while rst_i=1.
//   Reset mid-fetch abandons the outstanding request; a late rvalid in S_REQ is ignored.
//  FSM (one outstanding request max):
//   S_REQ : imem_req_o=1, imem_addr_o=pc_q -> S_WAIT next cycle (unless flush_i: stays S_REQ, pc_q<=target).
//   S_WAIT: wait for imem_rvalid_i. On rvalid:
//     drop_q=1          -> discard word, drop_q<=0, -> S_REQ.
//     stall_i=1         -> capture {pc_q,rdata} into hold buffer -> S_HOLD.
//     else              -> IF/ID<={pc_q,rdata,1}, pc_q<=pc_q+4, -> S_REQ.
//   S_HOLD: while stall_i=1 stay; when stall_i=0 -> IF/ID<=hold, pc_q<=pc_q+4, -> S_REQ.
//  Stall: IF/ID registers and pc_q hold; no new request issued beyond the outstanding one.
//  Flush (priority over stall, any state): pc_q<=branch_target_i & ~32'h3; IF/ID<={0,NOP_INSTR,0};
//   S_WAIT without rvalid this cycle: drop_q<=1 (in-flight word discarded later), stay S_WAIT;
//   S_WAIT with rvalid this cycle: word discarded, -> S_REQ; S_HOLD: hold buffer discarded, -> S_REQ.
//  Non-arrival cycles with stall_i=0: id_valid_o<=0 (bubble), id_instr_o<=NOP_INSTR.
//  Latency: req at cycle n, rvalid at n+k (k>=1) -> IF/ID valid at edge n+k+1; next req same cycle.
//   Peak throughput with k=1: one instruction per 2 cycles.
//  PC arithmetic: pc_q+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0); pc_q[1:0] always 00.
//  imem_rvalid_i in S_REQ or S_HOLD is a protocol error: ignored (assertion in bench).
// STRUCTURE
//  Shared package cpu_pkg: NOP_INSTR, fetch state enum {S_REQ,S_WAIT,S_HOLD}, XLEN.
//  One sub-module: pipe_reg (parameterised width, en/clr, sync reset value) used for IF/ID latch;
//  FSM, PC, hold buffer and drop flag live in if_id_stage.
// TESTING
//  Reset then rvalid k=1, words 0x00A00093,0x00100113 -> id_pc 0,4; valid pulses every 2nd cycle.
//  Variable latency k=3 -> imem_req_o single pulse per fetch, id_valid_o only at edge n+4.
//  stall_i high 3 cycles while word at pc 8 arrives -> IF/ID holds prior instr; pc 8 enters after release.
//  flush_i with target 0x0000_0102 during S_WAIT -> in-flight word dropped, next req addr 0x100, IF/ID=NOP,valid=0.
//  flush_i and stall_i same cycle in S_HOLD -> flush wins, hold discarded, next req at target.
//  pc_q=0xFFFF_FFFC fetch completes -> next imem_addr_o=0; rst_i mid-S_WAIT -> next req addr RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU front end: datapath width, the canonical NOP
// and the fetch FSM state encoding.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/response bus: one request pulse per fetch and an
// rvalid strobe that carries the returned word.
interface if_id_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and a clear that restores the reset
// value; clear wins over enable.
module pipe_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_d = q_q;
    if (clr_i)     q_d = RESET_VAL;
    else if (en_i) q_d = d_i;
  end

  // NOTE: state flops use non-blocking assignment so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC, single-outstanding fetch FSM, stall hold buffer, drop flag
// for squashed in-flight words, and the IF/ID register feeding decode.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP       = cpu_pkg::NOP_INSTR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       branch_target_i,
  if_id_stage_if.master         imem,
  output logic [XLEN-1:0]       id_pc_o,
  output logic [31:0]           id_instr_o,
  output logic                  id_valid_o
);

  localparam int IFID_W = XLEN + 33;
  localparam logic [IFID_W-1:0] IFID_EMPTY = {{XLEN{1'b0}}, NOP, 1'b0};

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            drop_d, drop_q;
  logic [XLEN-1:0] hold_pc_d, hold_pc_q;
  logic [31:0]     hold_instr_d, hold_instr_q;

  logic              ifid_en;
  logic [IFID_W-1:0] ifid_d, ifid_q;

  logic [XLEN-1:0] pc_next;
  assign pc_next = pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_en      = !stall_i;
    ifid_d       = IFID_EMPTY;

    if (flush_i) begin
      // Redirect beats stall; an in-flight word is either discarded now or marked for dropping.
      pc_d = {branch_target_i[XLEN-1:2], 2'b00};
      unique case (state_q)
        S_WAIT: begin
          if (imem.rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (imem.rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (stall_i) begin
              hold_pc_d    = pc_q;
              hold_instr_d = imem.rdata;
              state_d      = S_HOLD;
            end else begin
              ifid_d  = {pc_q, imem.rdata, 1'b1};
              pc_d    = pc_next;
              state_d = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            ifid_d  = {hold_pc_q, hold_instr_q, 1'b1};
            pc_d    = pc_next;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  pipe_reg #(
    .WIDTH    (IFID_W),
    .RESET_VAL(IFID_EMPTY)
  ) u_ifid (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (ifid_en),
    .clr_i(flush_i),
    .d_i  (ifid_d),
    .q_o  (ifid_q)
  );

  // A request issued under a redirect would fetch a dead address, so it is suppressed.
  assign imem.req  = (state_q == S_REQ) && !rst_i && !flush_i;
  assign imem.addr = pc_q;

  assign {id_pc_o, id_instr_o, id_valid_o} = ifid_q;

endmodule
